// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder (package dmem_pkg).
// Optional access statistics are enabled with DATA_MEM_ACCESS_STATS_EN.
package dmem_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int READ_LAT_MAX = 3;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} dmem_state_t;

  typedef logic [ADDR_W_DEF-1:0] dmem_addr_t;
  typedef logic [DATA_W_DEF-1:0] dmem_word_t;

  // Saturating 32-bit increment used by the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory port bundle; the core is the master, the memory the slave.
// Counter outputs exist only when DATA_MEM_ACCESS_STATS_EN is defined.
interface data_mem_responder_if import dmem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] RAddr_d;
  logic              Wen;
  logic [ADDR_W-1:0] WAddr_d;
  logic [DATA_W-1:0] Wdata_d;
  logic              clr_req;
  logic [DATA_W-1:0] Rdata_d;
  logic              ready;

`ifdef DATA_MEM_ACCESS_STATS_EN
  logic [31:0] wr_cnt;
  logic [31:0] fwd_cnt;

  modport master (output RAddr_d, Wen, WAddr_d, Wdata_d, clr_req,
                  input  Rdata_d, ready, wr_cnt, fwd_cnt);
  modport slave  (input  RAddr_d, Wen, WAddr_d, Wdata_d, clr_req,
                  output Rdata_d, ready, wr_cnt, fwd_cnt);
`else
  modport master (output RAddr_d, Wen, WAddr_d, Wdata_d, clr_req,
                  input  Rdata_d, ready);
  modport slave  (input  RAddr_d, Wen, WAddr_d, Wdata_d, clr_req,
                  output Rdata_d, ready);
`endif

endinterface

// File: rtl/data_mem_responder_rd_pipe.sv
// Read-data shift chain: READ_LAT registered stages, last stage is the read port output.
module dmem_rd_pipe #(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage [READ_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[READ_LAT-1];

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed synchronous SRAM responder with write-first forwarding and a clear FSM.
// Optional write/forward counters are enabled with DATA_MEM_ACCESS_STATS_EN.
module data_mem_responder import dmem_pkg::*; #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("data_mem_responder: READ_LAT must be in 1..3");
  end

  dmem_state_t       state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_ready;
  logic              wr_accept;
  logic              fwd_hit;
  logic [DATA_W-1:0] capture;

  assign in_ready  = (state == ST_READY);
  // A same-cycle clr_req wins over the write, which also suppresses forwarding.
  assign wr_accept = in_ready && bus.Wen && !bus.clr_req;
  assign fwd_hit   = wr_accept && (bus.WAddr_d == bus.RAddr_d);

  // NOTE: capture gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    capture = '0;
    if (fwd_hit)       capture = bus.Wdata_d;
    else if (in_ready) capture = mem[bus.RAddr_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == {ADDR_W{1'b1}}) state <= ST_READY;
        end
        ST_READY: begin
          if (bus.clr_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // NOTE: the array has no reset; zeroing is done by the CLEAR walk so the
  // storage maps onto plain SRAM without a per-word reset network.
  always_ff @(posedge clk) begin
    if (!in_ready)      mem[clr_addr]    <= '0;
    else if (wr_accept) mem[bus.WAddr_d] <= bus.Wdata_d;
  end

  dmem_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk (clk),
    .rst (rst),
    .d   (capture),
    .q   (bus.Rdata_d)
  );

  assign bus.ready = in_ready;

`ifdef DATA_MEM_ACCESS_STATS_EN
  logic [31:0] wr_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt  <= '0;
      fwd_cnt <= '0;
    end else if (in_ready && bus.clr_req) begin
      wr_cnt  <= '0;
      fwd_cnt <= '0;
    end else begin
      if (wr_accept) wr_cnt  <= sat_inc(wr_cnt);
      if (fwd_hit)   fwd_cnt <= sat_inc(fwd_cnt);
    end
  end

  assign bus.wr_cnt  = wr_cnt;
  assign bus.fwd_cnt = fwd_cnt;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: READ_LAT=1 and READ_LAT=3 instances share stimulus
// and are checked every cycle against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] raddr, waddr;
  logic              wen, clr_req;
  logic [DATA_W-1:0] wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  assign bus1.RAddr_d = raddr;
  assign bus1.Wen     = wen;
  assign bus1.WAddr_d = waddr;
  assign bus1.Wdata_d = wdata;
  assign bus1.clr_req = clr_req;
  assign bus3.RAddr_d = raddr;
  assign bus3.Wen     = wen;
  assign bus3.WAddr_d = waddr;
  assign bus3.Wdata_d = wdata;
  assign bus3.clr_req = clr_req;

  data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1), .CLEAR_ON_RESET(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3), .CLEAR_ON_RESET(1))
    u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory contents, cycles of clear remaining, and the values read
  // on the last three edges (index 0 = most recent).
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd  [3];
  logic [DATA_W-1:0] m_cap;
  logic              m_ready;
  int                m_left;
  logic [31:0]       m_wr, m_fwd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
      m_wr    = '0;
      m_fwd   = '0;
      for (int i = 0; i < 3; i++) m_rd[i] = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      if (!m_ready)                                  m_cap = '0;
      else if (wen && !clr_req && waddr == raddr)    m_cap = wdata;
      else                                           m_cap = m_mem[raddr];
      m_rd[2] = m_rd[1];
      m_rd[1] = m_rd[0];
      m_rd[0] = m_cap;
      if (m_ready) begin
        if (clr_req) begin
          m_ready = 1'b0;
          m_left  = DEPTH;
          m_wr    = '0;
          m_fwd   = '0;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (wen) begin
          m_mem[waddr] = wdata;
          if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
          if (waddr == raddr && m_fwd != 32'hFFFF_FFFF) m_fwd = m_fwd + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("ready_lat1", 32'(bus1.ready), 32'(m_ready));
    check("ready_lat3", 32'(bus3.ready), 32'(m_ready));
    check("rdata_lat1", bus1.Rdata_d, m_rd[0]);
    check("rdata_lat3", bus3.Rdata_d, m_rd[2]);
`ifdef DATA_MEM_ACCESS_STATS_EN
    check("wr_cnt",  bus1.wr_cnt,  m_wr);
    check("fwd_cnt", bus1.fwd_cnt, m_fwd);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until ready rises; optionally scribbles writes meanwhile.
  task automatic wait_ready(input string name, input bit scribble, input int first);
    int n = first;
    while (!bus1.ready && n < 3000) begin
      if (scribble) begin
        wen   = 1'b1;
        waddr = ADDR_W'(10'h020 + $urandom_range(0, 15));
        wdata = $urandom;
        clr_req = 1'($urandom_range(0, 1));
      end
      cyc();
      n++;
    end
    wen = 1'b0;
    clr_req = 1'b0;
    check(name, 32'(n), 32'd1024);
  endtask

  logic [31:0] fwd_before;

  initial begin
    rst = 1'b0; raddr = '0; waddr = '0; wen = 1'b0; wdata = '0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata1", bus1.Rdata_d, 32'h0);
    check("rst_ready",  32'(bus1.ready), 32'h0);
    rst = 1'b1;
    wait_ready("por_clear_len", 1'b0, 0);

    raddr = 10'h3FF; cyc();
    check("rd_3ff", bus1.Rdata_d, 32'h0);

    wen = 1'b1; waddr = 10'h005; wdata = 32'hDEADBEEF; raddr = 10'h000; cyc();
    wen = 1'b0; raddr = 10'h005; cyc();
    check("lat1_rd5", bus1.Rdata_d, 32'hDEADBEEF);
    check("lat3_not_yet", bus3.Rdata_d, 32'h0);
    cyc(); cyc();
    check("lat3_rd5", bus3.Rdata_d, 32'hDEADBEEF);

    fwd_before = m_fwd;
    wen = 1'b1; waddr = 10'h010; raddr = 10'h010; wdata = 32'h12345678; cyc();
    wen = 1'b0;
    check("fwd_lat1", bus1.Rdata_d, 32'h12345678);
`ifdef DATA_MEM_ACCESS_STATS_EN
    check("fwd_cnt_inc", bus1.fwd_cnt, fwd_before + 32'd1);
`endif
    raddr = 10'h000; cyc(); cyc();
    check("fwd_lat3", bus3.Rdata_d, 32'h12345678);

    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; waddr = ADDR_W'(i); wdata = 32'(i + 1); raddr = 10'h100; cyc();
    end
    wen = 1'b0;
    raddr = 10'h000; cyc(); check("b2b_0", bus1.Rdata_d, 32'd1);
    raddr = 10'h001; cyc(); check("b2b_1", bus1.Rdata_d, 32'd2);
    raddr = 10'h002; cyc(); check("b2b_2", bus1.Rdata_d, 32'd3);
    check("b2b_lat3_0", bus3.Rdata_d, 32'd1);
    raddr = 10'h003; wen = 1'b1; waddr = 10'h002; wdata = 32'd9; cyc();
    wen = 1'b0;
    check("b2b_3", bus1.Rdata_d, 32'd4);
    raddr = 10'h002; cyc();
    check("inflight_lat3", bus3.Rdata_d, 32'd3);
    check("reread_2", bus1.Rdata_d, 32'd9);
    cyc();
    check("b2b_lat3_3", bus3.Rdata_d, 32'd4);

    wen = 1'b1; waddr = 10'h020; wdata = 32'hAAAA5555; raddr = 10'h000; cyc();
    wdata = 32'h11111111; raddr = 10'h020; clr_req = 1'b1; cyc();
    wen = 1'b0; clr_req = 1'b0;
    check("drop_nofwd", bus1.Rdata_d, 32'hAAAA5555);
    check("clr_ready_low", 32'(bus1.ready), 32'h0);
    wait_ready("clr_req_len", 1'b1, 0);
    raddr = 10'h020; cyc();
    check("rd_020_zero", bus1.Rdata_d, 32'h0);

    clr_req = 1'b1; cyc(); clr_req = 1'b0;
    repeat (500) cyc();
    rst = 1'b0;
    #1;
    check("midclr_rdata1", bus1.Rdata_d, 32'h0);
    check("midclr_rdata3", bus3.Rdata_d, 32'h0);
    check("midclr_ready", 32'(bus1.ready), 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    wait_ready("restart_len", 1'b0, 0);

    for (int i = 0; i < 4000; i++) begin
      raddr   = ADDR_W'($urandom_range(0, 15));
      waddr   = ADDR_W'($urandom_range(0, 15));
      wen     = 1'($urandom_range(0, 1));
      wdata   = $urandom;
      clr_req = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    wen = 1'b0; clr_req = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory port. Serves the core's read address, write enable, write address and write data. Returns the read data.
- Word-addressed synchronous SRAM model with a configurable read-latency pipeline and write-first forwarding.
- A clear state machine zeroes the array after reset or on request. Sits beside the pipeline core in the top-level and testbench.

Parameters:
- ADDR_W, 10, word address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data word width.
- READ_LAT, 1, read latency in cycles; legal range 1..3; elaboration error outside this range.
- CLEAR_ON_RESET, 1, 1 = run CLEAR after reset; 0 = go straight to READY with array contents undefined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- RAddr_d  in  ADDR_W  read word address, sampled every cycle.
- Wen  in  1  write enable.
- WAddr_d  in  ADDR_W  write word address.
- Wdata_d  in  DATA_W  write data.
- clr_req  in  1  single-cycle request to re-zero the array.
- Rdata_d  out  DATA_W  read data, registered.
- ready  out  1  1 when the state is READY.

Behaviour:
- Reset (rst=0, asynchronous):
  - Rdata_d=0; all read-pipe stages=0.
  - Clear address=0.
  - State=CLEAR if CLEAR_ON_RESET else READY; ready follows the state.
- States:
  - CLEAR: each cycle writes 0 to mem[clr_addr], then increments clr_addr. When clr_addr=DEPTH-1 is written, go to READY next edge and reset clr_addr to 0. CLEAR lasts exactly DEPTH cycles.
  - READY: normal service. clr_req=1 moves to CLEAR on the next edge with clr_addr=0.
- Reads:
  - At every edge, RAddr_d is captured into stage 1 of the read pipe. Rdata_d presents the result READ_LAT edges after capture.
  - Reads are never stalled; one read is issued per cycle.
- Data captured into the pipe:
  - Capture in READY with Wen=1 and WAddr_d==RAddr_d: Wdata_d (write-first forwarding).
  - Otherwise in READY: mem[RAddr_d] as of that edge.
  - Capture in CLEAR: 0.
  - In-flight reads are not updated by later writes; data is fixed at capture time.
- Writes: in READY with Wen=1 and clr_req=0, mem[WAddr_d] <= Wdata_d at the edge.
- Dropped writes:
  - Wen=1 during CLEAR is dropped silently.
  - clr_req=1 with Wen=1 in the same READY cycle: clr_req wins and the write is dropped. The read captured that cycle returns mem contents without the dropped write and without forwarding.
- Arithmetic and addressing: clr_addr is ADDR_W bits. Addresses cover DEPTH exactly; there is no out-of-range case.
- clr_req in CLEAR: ignored; the clear does not restart.
- Reset mid-CLEAR: clear restarts from address 0.
- Exit from CLEAR: the first read capture returning array data is the edge after ready rises.

Optional Feature:
- Macro: DATA_MEM_ACCESS_STATS_EN.
- Defined:
  - Adds output wr_cnt (32 bit), counting accepted writes.
  - Adds output fwd_cnt (32 bit), counting write-first forwarding events.
  - Both counters saturate at all-ones.
  - Both reset to 0 on rst and on an accepted clr_req (the READY-to-CLEAR transition).
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - Constants: ADDR_W_DEF=10, DATA_W_DEF=32, READ_LAT_MAX=3.
  - State enum dmem_state_t {ST_CLEAR, ST_READY}.
  - Typedefs dmem_addr_t, dmem_word_t.
- One sub-module, dmem_rd_pipe:
  - A READ_LAT-deep register shift chain of DATA_W words with asynchronous active-low reset to 0.
  - Its last stage drives Rdata_d.
- Array, forwarding mux and FSM stay in data_mem_responder.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=1024 -> ready=0 for exactly 1024 cycles, then 1. Rdata_d=0 throughout. Read of address 0x3FF after ready returns 0.
- READ_LAT=1:
  - Write 0xDEADBEEF to 0x005, then read 0x005 next cycle -> Rdata_d=0xDEADBEEF one edge after capture.
  - With READ_LAT=3 -> the same value appears three edges after capture.
- Same-cycle Wen=1, WAddr_d=RAddr_d=0x010, Wdata_d=0x12345678, old value 0 -> forwarded 0x12345678. With the stats macro, fwd_cnt increments by 1.
- Back-to-back reads:
  - Fill 0x000..0x003 with 1..4.
  - Read 0..3 on consecutive cycles -> Rdata_d = 1,2,3,4 on consecutive cycles.
  - A write of 9 to 0x002 one cycle after its read capture -> the in-flight result is still 3.
- clr_req with Wen=1 to 0x020 in the same cycle -> write dropped; ready=0 next cycle for 1024 cycles. Wen during CLEAR has no effect. After ready, 0x020 reads 0.
- Assert rst=0 at CLEAR cycle 500 -> Rdata_d=0 immediately. CLEAR restarts and ready rises 1024 cycles after rst is released.
